// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation codes
// and the controller state encoding.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_unit_twos_abs.sv
// Conditional two's-complement negate; yields |x| when neg is the sign bit,
// or applies a result sign when neg is a sign flag.
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Sequential HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a final sign-fix cycle.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           state_dbg
);

  // Handshake: start is a one-cycle request accepted only while IDLE (which
  // includes the cycle done is high); done is a one-cycle completion pulse,
  // hi/lo are valid from that cycle and hold until the next completion.

  localparam int CW = $clog2(WIDTH);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div;
  logic                 res_neg;
  logic                 rem_neg;

  logic                 op_signed;
  logic                 op_div;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(a_neg), .y(a_mag));
  twos_abs #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(b_neg), .y(b_mag));

  // Multiply: multiplier sits in acc low half, partial product in high half.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  // Divide: dividend shifts out of acc low half while quotient bits shift in.
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  twos_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.x(acc),              .neg(res_neg), .y(prod_fix));
  twos_abs #(.WIDTH(WIDTH))   u_fix_quot (.x(acc[WIDTH-1:0]),   .neg(res_neg), .y(quot_fix));
  twos_abs #(.WIDTH(WIDTH))   u_fix_rem  (.x(rem),              .neg(rem_neg), .y(rem_fix));

  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_div && (b == '0)) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              opnd    <= op_div ? b_mag : a_mag;
              acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              rem     <= '0;
              cnt     <= '0;
              is_div  <= op_div;
              res_neg <= a_neg ^ b_neg;
              rem_neg <= a_neg;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            rem             <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc <= acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised + directed bench for mult_div_unit (WIDTH=32) with a queued
// scoreboard fed by an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  state_t       state_dbg;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // {div_zero, hi, lo}
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural values.
  task automatic push_expected(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint      sq, sr;
    logic        dz;
    dz = 1'b0;
    case (o)
      OP_MULT: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_DIV: begin
        if (y == '0) dz = 1'b1;
        else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      default: begin
        if (y == '0) dz = 1'b1;
        else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
    endcase
    exp_q.push_back({dz, m_hi, m_lo});
  endtask

  // driver: called #1 after a rising edge; returns #1 after the sampling edge E0
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    push_expected(o, x, y);
    @(posedge clock); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
  endtask

  // lat counts edges from E0 (inclusive) to the edge raising done
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: got no done after %0d edges, required done", lat);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (reset) begin
      if (div_zero && !done) check("div_zero_without_done", 64'(div_zero), 64'(0));
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          check("hi", 64'(hi), 64'(e[2*W-1:W]));
          check("lo", 64'(lo), 64'(e[W-1:0]));
          check("div_zero", 64'(div_zero), 64'(e[2*W]));
        end
      end
    end
  end

  initial begin
    int lat, bcnt, dc;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(IDLE));
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // 1: MULT 7 * -3, latency and busy length
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bcnt);
    check("t1_latency", 64'(lat), 64'(34));
    check("t1_busy_cycles", 64'(bcnt), 64'(33));
    check("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // 2: MULTU/MULT sign handling
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2); wait_done(lat, bcnt);
    issue(OP_MULT,  32'hFFFF_FFFF, 32'd2); wait_done(lat, bcnt);

    // 3: signed/unsigned divide and overflow wrap
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2); wait_done(lat, bcnt);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF); wait_done(lat, bcnt);
    check("t3_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(OP_DIVU, 32'd100, 32'd7); wait_done(lat, bcnt);

    // 4: divide by zero keeps hi/lo, no busy, done one edge after start
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(lat, bcnt);
    check("t4_latency", 64'(lat), 64'(1));
    check("t4_busy_cycles", 64'(bcnt), 64'(0));
    check("t4_hilo_held", {hi, lo}, {32'd2, 32'd14});

    // 5: start mid-CALC ignored; back-to-back start in done cycle accepted
    @(posedge clock); #1;
    dc = done_cnt;
    issue(OP_MULT, 32'h1234_5678, 32'h8765_4321);
    repeat (5) begin @(posedge clock); #1; end
    start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("t5_latency_after_ignored", 64'(lat), 64'(28));
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_0100);
    wait_done(lat, bcnt);
    check("t5_back_to_back_latency", 64'(lat), 64'(34));
    @(posedge clock); #1;
    check("t5_done_pulses", 64'(done_cnt - dc), 64'(2));

    // 6: asynchronous reset mid-CALC discards the operation
    issue(OP_MULT, 32'd1000, 32'd3000);
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_hilo", {hi, lo}, 64'(0));
    check("t6_state", 64'(state_dbg), 64'(IDLE));
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    dc = done_cnt;
    repeat (40) begin @(posedge clock); #1; end
    check("t6_no_done_after_reset", 64'(done_cnt - dc), 64'(0));
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    wait_done(lat, bcnt);
    check("t6_restart_latency", 64'(lat), 64'(34));

    // randomised operations with boundary classes mixed in
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        1: rb = '0;
        2: begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 5)); end
        3: rb = 32'($urandom_range(1, 255));
        default: ;
      endcase
      issue(ro, ra, rb);
      wait_done(lat, bcnt);
      check("rand_latency", 64'(lat), ((ro[1] && rb == '0) ? 64'(1) : 64'(34)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
      end
    end

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
